// File: rtl/upht_update_ctrl_if.sv
// Resolve-record and table write-port bundle for the uPHT update controller.
interface upht_update_ctrl_if #(
   parameter int IDX_W = 6,
   parameter int CW    = 3
);
   logic             i_resolve_vld;
   logic             o_resolve_rdy;
   logic [IDX_W-1:0] i_resolve_idx;
   logic [1:0]       i_resolve_cnt;
   logic             i_resolve_taken;
   logic             i_uPht_enable;
   logic             o_uPhtWrite_vld;
   logic [IDX_W-1:0] o_uPhtWr_addr;
   logic [1:0]       o_commit_Cnt;
   logic [CW-1:0]    o_pending_cnt;

   modport master (
      output i_resolve_vld, i_resolve_idx, i_resolve_cnt,
      output i_resolve_taken, i_uPht_enable,
      input  o_resolve_rdy, o_uPhtWrite_vld, o_uPhtWr_addr,
      input  o_commit_Cnt, o_pending_cnt
   );

   modport slave (
      input  i_resolve_vld, i_resolve_idx, i_resolve_cnt,
      input  i_resolve_taken, i_uPht_enable,
      output o_resolve_rdy, o_uPhtWrite_vld, o_uPhtWr_addr,
      output o_commit_Cnt, o_pending_cnt
   );
endinterface

// File: rtl/upht_update_ctrl.sv
// Commit-side uPHT writer: saturating counter update, in-order pending FIFO,
// forwarding from pending entries and the last committed write.
module upht_update_ctrl #(
   parameter int SAT_TABLE_SIZE = 64,
   parameter int FIFO_DEPTH     = 4
) (
   input logic               i_clk,
   input logic               i_rstn,
   upht_update_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(SAT_TABLE_SIZE);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];
   logic [1:0]       mem_cnt [FIFO_DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    scan_ptr;
   logic [CW-1:0]    count;
   logic             lw_vld;
   logic [IDX_W-1:0] lw_idx;
   logic [1:0]       lw_cnt;
   logic             push;
   logic             pop;
   logic             fwd_hit;
   logic [1:0]       fwd_cnt;
   logic [1:0]       base;
   logic [1:0]       next_cnt;

   assign bus.o_resolve_rdy   = (count != CW'(FIFO_DEPTH));
   assign bus.o_uPhtWrite_vld = (count != '0);
   assign bus.o_uPhtWr_addr   = mem_idx[rd_ptr];
   assign bus.o_commit_Cnt    = mem_cnt[rd_ptr];
   assign bus.o_pending_cnt   = count;

   assign push = bus.i_resolve_vld && bus.o_resolve_rdy;
   assign pop  = (count != '0) && bus.i_uPht_enable;

   // Scan oldest to youngest so the youngest match wins; head counts too.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_cnt  = 2'b00;
      scan_ptr = rd_ptr;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         scan_ptr = rd_ptr + PW'(i);
         if (CW'(i) < count && mem_idx[scan_ptr] == bus.i_resolve_idx) begin
            fwd_hit = 1'b1;
            fwd_cnt = mem_cnt[scan_ptr];
         end
      end
   end

   always_comb begin
      base = bus.i_resolve_cnt;
      if (fwd_hit)
         base = fwd_cnt;
      else if (lw_vld && lw_idx == bus.i_resolve_idx)
         base = lw_cnt;
      if (bus.i_resolve_taken)
         next_cnt = (base == 2'b11) ? 2'b11 : base + 2'd1;
      else
         next_cnt = (base == 2'b00) ? 2'b00 : base - 2'd1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_idx[i] <= '0;
            mem_cnt[i] <= 2'b01;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         lw_vld <= 1'b0;
         lw_idx <= '0;
         lw_cnt <= 2'b01;
      end else begin
         if (push) begin
            mem_idx[wr_ptr] <= bus.i_resolve_idx;
            mem_cnt[wr_ptr] <= next_cnt;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            lw_vld <= 1'b1;
            lw_idx <= mem_idx[rd_ptr];
            lw_cnt <= mem_cnt[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end
endmodule

// File: tb/tb_upht_update_ctrl.sv
// Directed vector bench for upht_update_ctrl: table of per-cycle
// stimulus/expectations plus a hand-written mid-operation reset sequence.
module tb_upht_update_ctrl;
   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   upht_update_ctrl_if #(.IDX_W(6), .CW(3)) bus ();

   upht_update_ctrl #(
      .SAT_TABLE_SIZE(64),
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [5:0] idx;
      logic [1:0] cnt;
      logic       taken;
      logic       en;
      logic       e_vld;
      logic [5:0] e_addr;
      logic [1:0] e_cnt;
      logic [2:0] e_pend;
      logic       e_rdy;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic vld, input int idx, input int cnt,
                      input logic taken, input logic en, input logic e_vld,
                      input int e_addr, input int e_cnt, input int e_pend,
                      input logic e_rdy);
      vec_t v;
      v.vld = vld; v.idx = 6'(idx); v.cnt = 2'(cnt); v.taken = taken;
      v.en = en; v.e_vld = e_vld; v.e_addr = 6'(e_addr);
      v.e_cnt = 2'(e_cnt); v.e_pend = 3'(e_pend); v.e_rdy = e_rdy;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [5:0] idx,
                        input logic [1:0] cnt, input logic taken,
                        input logic en);
      bus.i_resolve_vld   = vld;
      bus.i_resolve_idx   = idx;
      bus.i_resolve_cnt   = cnt;
      bus.i_resolve_taken = taken;
      bus.i_uPht_enable   = en;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_vld"}, int'(bus.o_uPhtWrite_vld), 0);
      chk({tag, "_addr"}, int'(bus.o_uPhtWr_addr), 0);
      chk({tag, "_cnt"}, int'(bus.o_commit_Cnt), 1);
      chk({tag, "_rdy"}, int'(bus.o_resolve_rdy), 1);
      chk({tag, "_pend"}, int'(bus.o_pending_cnt), 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
      rstn = 1'b0;

      //  vld idx cnt tk en | vld addr cnt pend rdy
      add(1,  5, 1, 1, 1,   1,  5, 2, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);
      add(1,  3, 3, 1, 1,   1,  3, 3, 1, 1);
      add(1,  4, 0, 0, 1,   1,  4, 0, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);
      add(1,  7, 1, 1, 0,   1,  7, 2, 1, 1);
      add(1,  7, 1, 1, 0,   1,  7, 2, 2, 1);
      add(1,  7, 1, 1, 0,   1,  7, 2, 3, 1);
      add(0,  0, 0, 0, 1,   1,  7, 3, 2, 1);
      add(0,  0, 0, 0, 1,   1,  7, 3, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);
      add(1,  7, 1, 0, 1,   1,  7, 2, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);
      add(1, 10, 0, 1, 0,   1, 10, 1, 1, 1);
      add(1, 11, 0, 1, 0,   1, 10, 1, 2, 1);
      add(1, 12, 0, 1, 0,   1, 10, 1, 3, 1);
      add(1, 13, 0, 1, 0,   1, 10, 1, 4, 0);
      add(1, 14, 0, 1, 0,   1, 10, 1, 4, 0);
      add(1, 14, 0, 1, 1,   1, 11, 1, 3, 1);
      add(1, 14, 0, 1, 1,   1, 12, 1, 3, 1);
      add(0,  0, 0, 0, 1,   1, 13, 1, 2, 1);
      add(1, 20, 2, 1, 1,   1, 14, 1, 2, 1);
      add(1, 21, 1, 0, 1,   1, 20, 3, 2, 1);
      add(0,  0, 0, 0, 1,   1, 21, 0, 1, 1);
      add(0,  0, 0, 0, 0,   1, 21, 0, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);
      add(1, 30, 0, 1, 0,   1, 30, 1, 1, 1);
      add(1, 30, 0, 1, 1,   1, 30, 2, 1, 1);
      add(0,  0, 0, 0, 1,   0,  0, 0, 0, 1);

      #12;
      chk_reset("in_reset");
      step();
      rstn = 1'b1;
      step();
      chk_reset("after_reset");

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].vld, vt[i].idx, vt[i].cnt, vt[i].taken, vt[i].en);
         step();
         chk($sformatf("v%0d_vld", i), int'(bus.o_uPhtWrite_vld),
             int'(vt[i].e_vld));
         chk($sformatf("v%0d_pend", i), int'(bus.o_pending_cnt),
             int'(vt[i].e_pend));
         chk($sformatf("v%0d_rdy", i), int'(bus.o_resolve_rdy),
             int'(vt[i].e_rdy));
         if (vt[i].e_vld) begin
            chk($sformatf("v%0d_addr", i), int'(bus.o_uPhtWr_addr),
                int'(vt[i].e_addr));
            chk($sformatf("v%0d_cnt", i), int'(bus.o_commit_Cnt),
                int'(vt[i].e_cnt));
         end
      end

      // Reset with three pending entries, then check nothing is replayed
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 6'(40 + i), 2'd1, 1'b1, 1'b0);
         step();
      end
      drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b1);
      chk("pre_rst_pend", int'(bus.o_pending_cnt), 3);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset("mid_reset");
      step();
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_rst_vld%0d", i), int'(bus.o_uPhtWrite_vld), 0);
      end
      // Last-write for idx 30 held 2 before reset; base must now be snapshot 0
      drive(1'b1, 6'd30, 2'd0, 1'b0, 1'b0);
      step();
      drive(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
      chk("post_rst_new_vld", int'(bus.o_uPhtWrite_vld), 1);
      chk("post_rst_new_addr", int'(bus.o_uPhtWr_addr), 30);
      chk("post_rst_new_cnt", int'(bus.o_commit_Cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/upht_update_ctrl.md
Name: upht_update_ctrl

Overview:
- Commit-side writer for the micro pattern-history table.
- Accepts resolved-branch records: table index, counter snapshot taken at predict time, actual outcome.
- Computes the saturating 2-bit next counter, buffers updates in a small in-order FIFO, and drives the table's write port (write valid / write address / commit count).
- Forwards pending and just-written values, so back-to-back updates to the same index never lose an increment.

Parameters:
- SAT_TABLE_SIZE, 64, number of table entries; IDX_W = $clog2(SAT_TABLE_SIZE).
- FIFO_DEPTH, 4, pending-update buffer entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_resolve_vld  in  1  resolved-branch record valid.
- o_resolve_rdy  out  1  record accepted when i_resolve_vld && o_resolve_rdy.
- i_resolve_idx  in  IDX_W  table index of the branch.
- i_resolve_cnt  in  2  counter value read at predict time (snapshot).
- i_resolve_taken  in  1  actual outcome, 1 = taken.
- i_uPht_enable  in  1  table write enable; a write is consumed only when this is high.
- o_uPhtWrite_vld  out  1  write request to the table.
- o_uPhtWr_addr  out  IDX_W  write index.
- o_commit_Cnt  out  2  new counter value.
- o_pending_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, i_rstn low): FIFO empty and read/write pointers cleared; last-write register invalid.
  - Output values during and after reset: o_uPhtWrite_vld=0, o_uPhtWr_addr=0, o_commit_Cnt=2'b01, o_resolve_rdy=1, o_pending_cnt=0.
  - Reset mid-operation discards all pending updates; nothing is replayed.
- Accept:
  - o_resolve_rdy = (o_pending_cnt != FIFO_DEPTH).
  - Same-cycle pop does not raise ready. Ready is purely occupancy-based, so there is no combinational path from i_uPht_enable.
- Base value selection, at enqueue, priority highest first:
  1. Youngest FIFO entry with a matching index, including the head being popped this cycle.
  2. Otherwise the last-write register, if valid and the index matches.
  3. Otherwise i_resolve_cnt.
- Next count:
  - Taken: base==2'b11 ? 2'b11 : base+1.
  - Not taken: base==2'b00 ? 2'b00 : base-1.
  - 2-bit arithmetic, no wrap.
- Enqueue: FIFO stores {idx, next count}.
- Write port:
  - o_uPhtWrite_vld = FIFO not empty; addr/count = FIFO head, driven from registers (no combinational input paths).
  - An accepted record appears on the write port the cycle after acceptance if the FIFO was empty (1-cycle latency).
- Pop:
  - Occurs when o_uPhtWrite_vld && i_uPht_enable.
  - On pop, the last-write register loads {head idx, head count} and becomes valid.
  - With i_uPht_enable low, the head is held stable and outputs do not change.
- Simultaneous push and pop: both occur, occupancy unchanged. An empty FIFO never pops in the same cycle as the push.
- Writes are always issued, even when the next count equals the base (saturated). The FIFO preserves update order.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from occupancy.

Test Plan:
- Reset, then a single record idx=5, cnt=01, taken=1, i_uPht_enable=1 -> next cycle vld=1, addr=5, Cnt=10; following cycle vld=0, pending=0.
- Saturation: idx=3, cnt=11, taken=1 -> Cnt=11. idx=4, cnt=00, taken=0 -> Cnt=00. Both writes issued.
- Forwarding:
  - i_uPht_enable=0; three records idx=7, cnt=01, taken=1 each -> queued Cnt 10, 11, 11.
  - Raise enable -> three writes to addr 7 in order with those values.
  - Then a record idx=7, cnt=01 (stale), taken=0 -> Cnt=10 (uses last-write 11).
- Backpressure: i_uPht_enable=0, push FIFO_DEPTH records -> rdy drops to 0 at pending=4, fifth record is held by the source.
  - Enable=1 -> one pop per cycle, rdy returns the cycle after the first pop, order preserved.
- Simultaneous push and pop at pending=2 -> pending stays 2. Written addr equals the head; the new entry lands at the tail, including across pointer wrap.
- Assert i_rstn low with pending=3 -> outputs immediately reset, no writes after release; a new record then uses i_resolve_cnt as base.
